seg7_scanner: RTL and testbench
===============================

SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, Clock cycles per digit slot (legal range 2..2^20).
REQ-002 Parameter: ACTIVE_LOW, default 1, 1 = seg/dp/an driven active-low; 0 = active-high.
REQ-003 Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  reset; asynchronous, active-low.
REQ-005 bcd0..bcd3  input  4 each  BCD digits, bcd0 least significant (rightmost).
REQ-006 update  input  1  single-cycle strobe; capture bcd0..3, neg, err into shadow registers.
REQ-007 neg  input  1  value is negative; display minus sign.
REQ-008 err  input  1  error condition; display "Err".
REQ-009 blank_lz  input  1  enable leading-zero blanking.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-011 dp  output  1  decimal point of the active digit, registered.
REQ-012 an  output  4  digit enables, one-hot when active, an[k] = position k, registered.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick asserted in the cycle it equals SCAN_DIV-1.
REQ-014 On tick, 2-bit digit index SHALL increment, wrapping 3->0.
REQ-015 seg/dp/an SHALL update on the Clock edge ending the tick cycle, from the new index; latency 1 cycle after tick.
REQ-016 Exactly one an bit SHALL be active after the first tick following reset.
REQ-017 update SHALL load shadow registers on the same edge; display SHALL use shadow values only, never live inputs.
REQ-018 update coincident with tick: new shadow values SHALL be used from the next output update; the current update uses old values.
REQ-019 blank_lz sampled live (not shadowed).
REQ-020 Active-high encodings {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-021 Shadow digit value 10..15 SHALL display blank (0000000).
REQ-022 Blanking: with blank_lz=1, position k (k=1..3) SHALL be blank when shadow digits k..3 are all zero; position 0 never blanked.
REQ-023 Minus: with neg=1, minus (1000000) SHALL display at the lowest blanked position, i.e. one left of the highest shown digit.
REQ-024 neg=1 with no blanked position (blank_lz=0 or digit 3 nonzero): no minus; dp SHALL light on position 3 as overflow marker.
REQ-025 dp SHALL be inactive on all other positions and in all other cases.
REQ-026 err=1 in shadow SHALL override all: positions 3,2,1,0 show E=1111001, r=1010000, r=1010000, blank; dp off.
REQ-027 ACTIVE_LOW=1 SHALL invert seg, dp and an relative to the active-high definitions.

Reset
REQ-028 Reset asserted SHALL immediately clear prescaler, digit index, shadow registers (digits 0, neg 0, err 0).
REQ-029 During and after reset until the first output update, seg, dp and an SHALL be inactive (ACTIVE_LOW=1: all ones).
REQ-030 Reset mid-scan SHALL abandon the current slot; scanning restarts with the prescaler at 0.

Verification (SCAN_DIV=4, ACTIVE_LOW=0)
REQ-031 Release reset, no update -> outputs 0 for 4 cycles; after first tick an=0010, seg=0111111 on position 1 when blank_lz=0.
REQ-032 update with bcd3..0=0,0,4,2, blank_lz=1, neg=0 -> over one full scan: pos0 1011011, pos1 1100110, pos2 and pos3 seg=0000000.
REQ-033 Same digits, neg=1 -> pos2 seg=1000000, pos3 blank, dp=0 everywhere.
REQ-034 bcd3..0=9,8,7,6, neg=1, blank_lz=1 -> no minus; pos3 seg=1101111 and dp=1; other dp=0.
REQ-035 err=1 with update -> pos3 1111001, pos2 1010000, pos1 1010000, pos0 0000000; bcd inputs changed without update -> display unchanged.
REQ-036 Reset pulsed mid-slot -> an/seg/dp to 0 asynchronously; next an change exactly 4 cycles after release.

Source files
------------

// File: rtl/seg7_scanner.sv
// Four-digit multiplexed 7-segment scanner: shadowed BCD value, leading-zero
// blanking, minus sign or overflow point, and an "Err" override.
module seg7_scanner #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic       update,
  input  logic       neg,
  input  logic       err,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned   PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0]    SEG_MINUS = 7'b1000000;
  localparam logic [6:0]    SEG_E     = 7'b1111001;
  localparam logic [6:0]    SEG_R     = 7'b1010000;
  localparam logic [6:0]    SEG_POL   = {7{ACTIVE_LOW}};
  localparam logic [3:0]    AN_POL    = {4{ACTIVE_LOW}};

  generate
    if (SCAN_DIV < 2 || SCAN_DIV > 32'd1048576) begin : g_bad_div
      $error("seg7_scanner: SCAN_DIV out of range 2..2^20");
    end
  endgenerate

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic       tick;
  logic [3:0] blank;
  logic [3:0] minus;
  logic       ovf;
  logic [3:0] digit_sel;
  logic [6:0] seg_act;
  logic       dp_act;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign tick     = (presc_q == PRESC_MAX);
  assign presc_d  = tick ? '0 : presc_q + PW'(1);
  assign idx_d    = idx_q + {1'b0, tick};
  assign shadow_d = update ? {bcd3, bcd2, bcd1, bcd0} : shadow_q;
  assign neg_d    = update ? neg : neg_q;
  assign err_d    = update ? err : err_q;

  // Position k is blank when it and every digit to its left are zero;
  // the minus sign sits in the lowest such position.
  assign blank[0] = 1'b0;
  assign minus[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign blank[gi] = blank_lz && (shadow_q[15:4*gi] == '0);
      assign minus[gi] = neg_q && blank[gi] && !blank[gi-1];
    end
  endgenerate
  assign ovf = neg_q && !blank[3];

  // Output values are built for the index the slot is about to move to.
  always_comb begin
    digit_sel = shadow_q[{idx_d, 2'b00} +: 4];
    seg_act   = seg_decode(digit_sel);
    dp_act    = ovf && (idx_d == 2'd3);
    if (blank[idx_d]) seg_act = 7'b0000000;
    if (minus[idx_d]) seg_act = SEG_MINUS;
    if (err_q) begin
      dp_act = 1'b0;
      case (idx_d)
        2'd3:       seg_act = SEG_E;
        2'd2, 2'd1: seg_act = SEG_R;
        default:    seg_act = 7'b0000000;
      endcase
    end
  end

  assign seg_d = tick ? (seg_act ^ SEG_POL) : seg_q;
  assign dp_d  = tick ? (dp_act ^ ACTIVE_LOW) : dp_q;
  assign an_d  = tick ? ((4'b0001 << idx_d) ^ AN_POL) : an_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      seg_q    <= SEG_POL;
      dp_q     <= ACTIVE_LOW;
      an_q     <= AN_POL;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner (SCAN_DIV=4, active-high outputs): each
// expected slot is queued when stimulus is applied and checked on digit change.
module tb_seg7_scanner;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] bcd0 = 4'd0, bcd1 = 4'd0, bcd2 = 4'd0, bcd3 = 4'd0;
  logic       update = 1'b0, neg = 1'b0, err = 1'b0, blank_lz = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  always #5 Clock = ~Clock;

  seg7_scanner #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut (
    .Clock(Clock), .Reset(Reset),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .update(update), .neg(neg), .err(err), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         push_pos = 1;
  int         last_change_cyc = 0;
  logic [3:0] last_an = 4'b0000;

  // Reference model of what the display should hold.
  logic [3:0] m_d[4];
  logic       m_neg = 1'b0, m_err = 1'b0, m_blz = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic slot_t model(input int pos);
    slot_t s;
    int    hi;
    s.an  = 4'(1 << pos);
    s.seg = 7'b0000000;
    s.dp  = 1'b0;
    hi = 0;
    for (int k = 0; k < 4; k++) if (m_d[k] != 4'd0) hi = k;
    if (m_err) begin
      if (pos == 3) s.seg = 7'b1111001;
      else if (pos != 0) s.seg = 7'b1010000;
    end else begin
      s.seg = (m_blz && pos > hi) ? 7'b0000000 : enc(m_d[pos]);
      if (m_neg && m_blz && hi < 3 && pos == hi + 1) s.seg = 7'b1000000;
      if (m_neg && pos == 3 && !(m_blz && hi < 3)) s.dp = 1'b1;
    end
    return s;
  endfunction

  task automatic push_slots(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model(push_pos));
      push_pos = (push_pos + 1) % 4;
    end
  endtask

  task automatic set_model(input logic [3:0] d3, d2, d1, d0, input logic n, e);
    m_d[3] = d3; m_d[2] = d2; m_d[1] = d1; m_d[0] = d0;
    m_neg = n; m_err = e;
  endtask

  // Wait for the next digit change, then compare it with the queue head.
  task automatic pop_check(input string name, input int exp_cycles);
    int    waited;
    bit    seen;
    slot_t e;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 12) begin
      @(negedge Clock);
      waited++;
      if (an !== last_an) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no digit change within 12 cycles, an=%b", name, an);
      return;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected digit change an=%b seg=%b dp=%b", name, an, seg, dp);
      return;
    end
    e = exp_q.pop_front();
    $display("slot %-10s an=%b seg=%b dp=%b (expect an=%b seg=%b dp=%b) after %0d cycles",
             name, an, seg, dp, e.an, e.seg, e.dp, cyc - last_change_cyc);
    if (an !== e.an) begin
      errors++;
      $display("FAIL %s an: got %b expected %b", name, an, e.an);
    end
    checks++;
    if (seg !== e.seg) begin
      errors++;
      $display("FAIL %s seg: got %b expected %b", name, seg, e.seg);
    end
    checks++;
    if (dp !== e.dp) begin
      errors++;
      $display("FAIL %s dp: got %b expected %b", name, dp, e.dp);
    end
    if (exp_cycles > 0) begin
      checks++;
      if (cyc - last_change_cyc !== exp_cycles) begin
        errors++;
        $display("FAIL %s period: got %0d cycles expected %0d", name, cyc - last_change_cyc, exp_cycles);
      end
    end
    last_an = an;
    last_change_cyc = cyc;
  endtask

  task automatic do_update(input logic [3:0] d3, d2, d1, d0, input logic n, e, blz);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
    neg = n; err = e; blank_lz = blz; update = 1'b1;
    set_model(d3, d2, d1, d0, n, e);
    m_blz = blz;
    push_slots(4);
    @(negedge Clock);
    update = 1'b0;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({an, seg, dp} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: got an=%b seg=%b dp=%b expected all 0", an, seg, dp);
    end
    set_model(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    m_blz = 1'b0;
    blank_lz = 1'b0;
    Reset = 1'b1;
    last_change_cyc = cyc;
    last_an = 4'b0000;
    push_pos = 1;
    for (int i = 1; i < 4; i++) begin
      @(negedge Clock);
      checks++;
      if ({an, seg, dp} !== 12'h000) begin
        errors++;
        $display("FAIL pre_tick%0d: got an=%b seg=%b dp=%b expected all 0", i, an, seg, dp);
      end
    end
    push_slots(4);
    for (int i = 0; i < 4; i++) pop_check("zeros", 4);
  endtask

  task automatic test_blanking();
    do_update(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("blank_lz", 4);
  endtask

  task automatic test_minus();
    do_update(4'd0, 4'd0, 4'd4, 4'd2, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("minus", 4);
  endtask

  task automatic test_overflow();
    do_update(4'd9, 4'd8, 4'd7, 4'd6, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("overflow", 4);
  endtask

  task automatic test_err();
    do_update(4'd3, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("err", 4);
    // Live inputs move without a strobe; display must not follow them.
    bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd4;
    err = 1'b0; neg = 1'b1;
    push_slots(4);
    for (int i = 0; i < 4; i++) pop_check("err_hold", 4);
  endtask

  task automatic test_back_to_back();
    repeat (3) @(negedge Clock);
    // Strobe lands on the tick edge: that slot still shows the old shadow.
    bcd3 = 4'd0; bcd2 = 4'd12; bcd1 = 4'd0; bcd0 = 4'd5;
    neg = 1'b1; err = 1'b0; blank_lz = 1'b0; update = 1'b1;
    m_blz = 1'b0;
    push_slots(1);
    set_model(4'd0, 4'd12, 4'd0, 4'd5, 1'b1, 1'b0);
    push_slots(3);
    pop_check("coincide", 4);
    update = 1'b0;
    for (int i = 0; i < 3; i++) pop_check("new_val", 4);
  endtask

  task automatic test_reset_mid();
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b expected all 0", an, seg, dp);
    end
    @(negedge Clock);
    set_model(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    blank_lz = 1'b1;
    m_blz = 1'b1;
    Reset = 1'b1;
    last_change_cyc = cyc;
    last_an = 4'b0000;
    push_pos = 1;
    push_slots(4);
    for (int i = 0; i < 4; i++) pop_check("restart", 4);
  endtask

  initial begin
    test_reset();
    test_blanking();
    test_minus();
    test_overflow();
    test_err();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
